// File: rtl/itoa_emit_if.sv
// mb8_io: byte-wide memory bus used by ForthSuper blocks.
// The master drives a write strobe, a byte address and the byte value.
interface mb8_io #(
  parameter int DSZ = 8,
  parameter int ASZ = 17
);
  logic           we;
  logic [ASZ-1:0] ai;
  logic [DSZ-1:0] vi;

  modport master (output we, output ai, output vi);
  modport slave  (input  we, input  ai, input  vi);
endinterface

// File: rtl/itoa_emit.sv
// itoa_emit: converts a 32-bit value into ASCII digits (decimal or hex)
// and writes them, followed by one space, into byte memory over mb8_io.
// Decimal uses a 32-cycle double-dabble; hex uses the raw nibbles.
// Optional feature macro: ITOA_SIGNED_EN (decimal values become signed,
// negative values get a leading '-').
module itoa_emit #(
  parameter int DSZ = 8,
  parameter int ASZ = 17
) (
  input  logic           clk,
  input  logic           rst,
  mb8_io.master          mb_if,
  input  logic           en,
  input  logic           hex,
  input  logic [31:0]    vi,
  input  logic [ASZ-1:0] ai,
  output logic           bsy,
  output logic [ASZ-1:0] ao
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CNV  = 3'd1,
    S_LDZ  = 3'd2,
    S_NEG  = 3'd3,
    S_EMT  = 3'd4,
    S_SPC  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift
  // the combined {bcd, bin} register left by one bit.
  function automatic logic [71:0] dabble_step(input logic [39:0] bcd,
                                              input logic [31:0] bin);
    logic [39:0] adj;
    adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = adj[4*i +: 4];
      end
    end
    dabble_step = {adj[38:0], bin, 1'b0};
  endfunction

  // Number of significant digits: index of highest nonzero nibble + 1,
  // never less than 1 so that zero still prints one digit.
  function automatic logic [3:0] digit_count(input logic [39:0] d);
    digit_count = 4'd1;
    for (int i = 0; i < 10; i++) begin
      if (d[4*i +: 4] != 4'd0) begin
        digit_count = 4'(i + 1);
      end else begin
        digit_count = digit_count;
      end
    end
  endfunction

  // Digit to ASCII: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  function automatic logic [7:0] ascii_of(input logic [3:0] d);
    if (d < 4'd10) begin
      ascii_of = 8'h30 + {4'd0, d};
    end else begin
      ascii_of = 8'h37 + {4'd0, d};
    end
  endfunction

  state_t         state_r, state_nx;
  logic [ASZ-1:0] ptr_r, ptr_nx;
  logic [39:0]    dig_r, dig_nx;
  logic [31:0]    bin_r, bin_nx;
  logic [4:0]     cnt_r, cnt_nx;
  logic           neg_r, neg_nx;
  logic           we_r, we_nx;
  logic [DSZ-1:0] vi_r, vi_nx;
  logic           bsy_r, bsy_nx;
  logic [ASZ-1:0] ao_r, ao_nx;

  logic           neg_in_s;
  logic [31:0]    mag_s;
  logic [71:0]    dab_s;
  logic [3:0]     n_s;
  logic [5:0]     shamt_s;

`ifdef ITOA_SIGNED_EN
  assign neg_in_s = ~hex & vi[31];
`else
  assign neg_in_s = 1'b0;
`endif

  assign mag_s   = neg_in_s ? (32'd0 - vi) : vi;
  assign dab_s   = dabble_step(dig_r, bin_r);
  assign n_s     = digit_count(dig_r);
  // Left-align the significant digits so the MSD sits in dig[39:36].
  assign shamt_s = {4'd10 - n_s, 2'b00};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; dropping en anywhere outside IDLE aborts.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: begin
        if (en) begin
          state_nx = hex ? S_LDZ : S_CNV;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_CNV: begin
        if (!en) begin
          state_nx = S_IDLE;
        end else if (cnt_r == 5'd31) begin
          state_nx = S_LDZ;
        end else begin
          state_nx = S_CNV;
        end
      end
      S_LDZ: begin
        if (!en) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = neg_r ? S_NEG : S_EMT;
        end
      end
      S_NEG: begin
        if (!en) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_EMT;
        end
      end
      S_EMT: begin
        if (!en) begin
          state_nx = S_IDLE;
        end else if (cnt_r == 5'd0) begin
          state_nx = S_SPC;
        end else begin
          state_nx = S_EMT;
        end
      end
      S_SPC: begin
        if (!en) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (!en) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_DONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and output next values, decoded from the next state so the
  // bus and status outputs come straight from flops.
  always_comb begin
    ptr_nx = ptr_r;
    dig_nx = dig_r;
    bin_nx = bin_r;
    cnt_nx = cnt_r;
    neg_nx = neg_r;
    case (state_r)
      S_IDLE: begin
        if (en) begin
          ptr_nx = ai;
          neg_nx = neg_in_s;
          bin_nx = mag_s;
          dig_nx = hex ? {8'd0, mag_s} : 40'd0;
          cnt_nx = 5'd0;
        end else begin
          ptr_nx = ptr_r;
        end
      end
      S_CNV: begin
        dig_nx = dab_s[71:32];
        bin_nx = dab_s[31:0];
        cnt_nx = cnt_r + 5'd1;
      end
      S_LDZ: begin
        dig_nx = dig_r << shamt_s;
        cnt_nx = {1'b0, n_s} - 5'd1;
      end
      S_NEG: begin
        ptr_nx = ptr_r + ASZ'(1);
      end
      S_EMT: begin
        ptr_nx = ptr_r + ASZ'(1);
        dig_nx = {dig_r[35:0], 4'd0};
        cnt_nx = cnt_r - 5'd1;
      end
      S_SPC: begin
        ptr_nx = ptr_r + ASZ'(1);
      end
      default: begin
        ptr_nx = ptr_r;
      end
    endcase

    case (state_nx)
      S_NEG: begin
        we_nx = 1'b1;
        vi_nx = DSZ'(8'h2D);
      end
      S_EMT: begin
        we_nx = 1'b1;
        vi_nx = DSZ'(ascii_of(dig_nx[39:36]));
      end
      S_SPC: begin
        we_nx = 1'b1;
        vi_nx = DSZ'(8'h20);
      end
      default: begin
        we_nx = 1'b0;
        vi_nx = '0;
      end
    endcase

    if ((state_nx == S_IDLE) || (state_nx == S_DONE)) begin
      bsy_nx = 1'b0;
    end else begin
      bsy_nx = 1'b1;
    end

    if ((state_r == S_SPC) && (state_nx == S_DONE)) begin
      ao_nx = ptr_nx;
    end else begin
      ao_nx = ao_r;
    end
  end

  // Datapath and registered outputs; reset clears the write strobe at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
      dig_r <= 40'd0;
      bin_r <= 32'd0;
      cnt_r <= 5'd0;
      neg_r <= 1'b0;
      we_r  <= 1'b0;
      vi_r  <= '0;
      bsy_r <= 1'b0;
      ao_r  <= '0;
    end else begin
      ptr_r <= ptr_nx;
      dig_r <= dig_nx;
      bin_r <= bin_nx;
      cnt_r <= cnt_nx;
      neg_r <= neg_nx;
      we_r  <= we_nx;
      vi_r  <= vi_nx;
      bsy_r <= bsy_nx;
      ao_r  <= ao_nx;
    end
  end

  assign mb_if.we = we_r;
  assign mb_if.ai = ptr_r;
  assign mb_if.vi = vi_r;
  assign bsy      = bsy_r;
  assign ao       = ao_r;

endmodule

// File: tb/tb_itoa_emit.sv
// Directed testbench for itoa_emit: checks written bytes, addresses,
// busy duration, end address, abort and asynchronous reset behaviour.
module tb_itoa_emit;

  localparam int DSZ = 8;
  localparam int ASZ = 17;

  logic           clk;
  logic           rst;
  logic           en;
  logic           hex;
  logic [31:0]    vi;
  logic [ASZ-1:0] ai;
  logic           bsy;
  logic [ASZ-1:0] ao;
  logic           log_clr;

  int n_checks;
  int n_errs;

  logic [ASZ-1:0] wr_addr [0:31];
  logic [DSZ-1:0] wr_data [0:31];
  int             wr_cnt;

  mb8_io #(.DSZ(DSZ), .ASZ(ASZ)) mb ();

  itoa_emit #(.DSZ(DSZ), .ASZ(ASZ)) dut (
    .clk   (clk),
    .rst   (rst),
    .mb_if (mb),
    .en    (en),
    .hex   (hex),
    .vi    (vi),
    .ai    (ai),
    .bsy   (bsy),
    .ao    (ao)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every byte write seen on the bus.
  always @(posedge clk) begin
    if (log_clr) begin
      wr_cnt = 0;
    end else if (mb.we && (wr_cnt < 32)) begin
      wr_addr[wr_cnt] = mb.ai;
      wr_data[wr_cnt] = mb.vi;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Run one conversion with en held and check everything about it.
  task automatic run_conv(input string tag, input logic h, input logic [31:0] v,
                          input logic [ASZ-1:0] a, input string exp_s,
                          input int exp_bsy);
    int bsy_cyc;
    int we_cyc;
    int guard;
    int len;
    logic [ASZ-1:0] exp_addr;
    len = exp_s.len();
    @(negedge clk);
    log_clr = 1'b1;
    en = 1'b0;
    @(negedge clk);
    log_clr = 1'b0;
    hex = h;
    vi = v;
    ai = a;
    en = 1'b1;
    @(negedge clk);
    bsy_cyc = 0;
    we_cyc = 0;
    guard = 0;
    while (bsy && (guard < 200)) begin
      bsy_cyc++;
      if (mb.we) we_cyc++;
      @(negedge clk);
      guard++;
    end
    check_eq({tag, " bsy_drop"}, {31'd0, bsy}, 32'd0);
    check_eq({tag, " bsy_cycles"}, bsy_cyc, exp_bsy);
    check_eq({tag, " we_cycles"}, we_cyc, len);
    check_eq({tag, " ao"}, {15'd0, ao}, {15'd0, a + ASZ'(len)});
    check_eq({tag, " nbytes"}, wr_cnt, len);
    for (int i = 0; i < len; i++) begin
      exp_addr = a + ASZ'(i);
      check_eq($sformatf("%s addr%0d", tag, i), {15'd0, wr_addr[i]}, {15'd0, exp_addr});
      check_eq($sformatf("%s byte%0d", tag, i), {24'd0, wr_data[i]}, {24'd0, exp_s[i]});
    end
    repeat (3) @(negedge clk);
    check_eq({tag, " done_hold_bsy"}, {31'd0, bsy}, 32'd0);
    check_eq({tag, " done_hold_writes"}, wr_cnt, len);
    en = 1'b0;
  endtask

  initial begin
    int guard;
    n_checks = 0;
    n_errs = 0;
    rst = 1'b0;
    en = 1'b0;
    hex = 1'b0;
    vi = 32'd0;
    ai = '0;
    log_clr = 1'b1;
    #1;
    check_eq("reset bsy", {31'd0, bsy}, 32'd0);
    check_eq("reset we", {31'd0, mb.we}, 32'd0);
    check_eq("reset ai", {15'd0, mb.ai}, 32'd0);
    check_eq("reset vi", {24'd0, mb.vi}, 32'd0);
    check_eq("reset ao", {15'd0, ao}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_conv("dec123", 1'b0, 32'd123, 17'h100, "123 ", 37);
    run_conv("dec0", 1'b0, 32'd0, 17'h080, "0 ", 35);
`ifdef ITOA_SIGNED_EN
    run_conv("decm1", 1'b0, 32'hFFFF_FFFF, 17'h040, "-1 ", 36);
    run_conv("decmin", 1'b0, 32'h8000_0000, 17'h500, "-2147483648 ", 45);
`else
    run_conv("decm1", 1'b0, 32'hFFFF_FFFF, 17'h040, "4294967295 ", 44);
    run_conv("decmin", 1'b0, 32'h8000_0000, 17'h500, "2147483648 ", 44);
`endif
    run_conv("hexcoffee", 1'b1, 32'h00C0_FFEE, 17'h1FFFE, "C0FFEE ", 8);
    run_conv("hexff", 1'b1, 32'hFFFF_FFFF, 17'h020, "FFFFFFFF ", 10);
    run_conv("hex0", 1'b1, 32'h0000_0000, 17'h030, "0 ", 3);
    run_conv("hexm1dec", 1'b1, 32'h8000_0000, 17'h600, "80000000 ", 10);

    // Abort during decimal conversion: no writes, IDLE after one edge.
    @(negedge clk);
    log_clr = 1'b1;
    en = 1'b0;
    @(negedge clk);
    log_clr = 1'b0;
    hex = 1'b0;
    vi = 32'd12345;
    ai = 17'h200;
    en = 1'b1;
    repeat (11) @(negedge clk);
    check_eq("abort bsy_before", {31'd0, bsy}, 32'd1);
    en = 1'b0;
    @(negedge clk);
    check_eq("abort bsy_after", {31'd0, bsy}, 32'd0);
    check_eq("abort we_after", {31'd0, mb.we}, 32'd0);
    repeat (40) @(negedge clk);
    check_eq("abort no_writes", wr_cnt, 0);

    // Asynchronous reset during digit emission.
    @(negedge clk);
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
    hex = 1'b1;
    vi = 32'h1234_5678;
    ai = 17'h300;
    en = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!mb.we && (guard < 20)) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check_eq("rstmid we_before", {31'd0, mb.we}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rstmid we", {31'd0, mb.we}, 32'd0);
    check_eq("rstmid bsy", {31'd0, bsy}, 32'd0);
    check_eq("rstmid ai", {15'd0, mb.ai}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_conv("restart", 1'b1, 32'h0000_000A, 17'h010, "A ", 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
